data_mem_responder: RTL and testbench

//  Target side of the data-memory interface driven by the MEM stage.

---
 rtl/data_mem_responder_pkg.sv | 75 +++++++
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/data_mem_responder_array.sv | 33 +++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Access-size codes, FSM states and lane-steering helpers for
//               the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    localparam logic [1:0] c_size_byte    = 2'b00;
    localparam logic [1:0] c_size_half    = 2'b01;
    localparam logic [1:0] c_size_word    = 2'b10;
    localparam logic [1:0] c_size_illegal = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic access_fault(input logic [31:0] addr,
                                          input logic [1:0]  size,
                                          input int unsigned depth_words);
        logic f;
        case (size)
            c_size_byte: f = 1'b0;
            c_size_half: f = addr[0];
            c_size_word: f = |addr[1:0];
            default:     f = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= depth_words) begin
            f = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size,
                                            input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            c_size_byte: be = 4'b0001 << lo;
            c_size_half: be = 4'b0011 << lo;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data so every enabled lane sees the right byte(s).
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            c_size_byte: lanes = {4{data[7:0]}};
            c_size_half: lanes = {2{data[15:0]}};
            default:     lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_align(input logic [1:0]  size,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {lo, 3'b000};
        case (size)
            c_size_byte: res = {24'd0, shifted[7:0]};
            c_size_half: res = {16'd0, shifted[15:0]};
            default:     res = shifted;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : MEM-stage to data-memory request/response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;

    logic        mreq;
    logic        write;
    logic [31:0] addr;
    logic [1:0]  access_size;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        fault;
    logic        busy;

    modport master (
        output mreq, write, addr, access_size, wr_data,
        input  rd_data, ready, fault, busy
    );

    modport slave (
        input  mreq, write, addr, access_size, wr_data,
        output rd_data, ready, fault, busy
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_array
// Description : Word array with four byte-lane write enables, synchronous
//               write and combinational read. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int c_idx_w = $clog2(DEPTH_WORDS)
) (
    input  wire                 clk,
    input  wire                 i_we,
    input  wire  [3:0]          i_be,
    input  wire  [c_idx_w-1:0]  i_idx,
    input  wire  [31:0]         i_wdata,
    output logic [31:0]         o_rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (i_we && i_be[g]) begin
                r_mem[i_idx] <= i_wdata[8*g +: 8];
            end
        end

        assign o_rdata[8*g +: 8] = r_mem[i_idx];
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory target: accepts load/store requests, responds
//               after LATENCY wait cycles with a one-cycle ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  wire                    clk,
    input  wire                    rst_n,
    data_mem_responder_if.slave    bus
);

    localparam int         c_idx_w   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_latency = 4'(LATENCY);

    state_e      r_state;
    logic [3:0]  r_count;
    logic        r_write;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wr_data;
    logic        r_ready;
    logic        r_fault;
    logic [31:0] r_rd_data;

    logic        w_live;
    logic        w_write;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic [31:0] w_wr_data;
    logic        w_fault;
    logic        w_enter_resp;
    logic        w_commit;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;
    logic [31:0] w_word;
    logic [31:0] w_resp_data;

    // In IDLE the live bus is the request (only matters for a zero-latency
    // build, which responds on the accept edge); otherwise the captured copy.
    assign w_live    = (r_state == ST_IDLE);
    assign w_write   = w_live ? bus.write       : r_write;
    assign w_addr    = w_live ? bus.addr        : r_addr;
    assign w_size    = w_live ? bus.access_size : r_size;
    assign w_wr_data = w_live ? bus.wr_data     : r_wr_data;

    assign w_fault      = access_fault(w_addr, w_size, DEPTH_WORDS);
    assign w_enter_resp = ((r_state == ST_IDLE) && bus.mreq && (LATENCY == 0)) ||
                          ((r_state == ST_WAIT) && (r_count == c_latency));
    assign w_commit     = rst_n && w_enter_resp && w_write && !w_fault;
    assign w_be         = store_be(w_size, w_addr[1:0]);
    assign w_lanes      = store_lanes(w_size, w_wr_data);
    assign w_resp_data  = (w_write || w_fault) ? 32'd0
                                               : load_align(w_size, w_addr[1:0], w_word);

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit),
        .i_be    (w_be),
        .i_idx   (w_addr[c_idx_w+1:2]),
        .i_wdata (w_lanes),
        .o_rdata (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= 4'd0;
            r_write   <= 1'b0;
            r_addr    <= 32'd0;
            r_size    <= 2'b00;
            r_wr_data <= 32'd0;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
            r_rd_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mreq) begin
                        r_write   <= bus.write;
                        r_addr    <= bus.addr;
                        r_size    <= bus.access_size;
                        r_wr_data <= bus.wr_data;
                        r_count   <= 4'd1;
                        if (LATENCY == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_enter_resp) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_count <= r_count + 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_count <= 4'd0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            r_ready   <= w_enter_resp;
            r_fault   <= w_enter_resp && w_fault;
            r_rd_data <= w_enter_resp ? w_resp_data : 32'd0;
        end
    end

    assign bus.ready   = r_ready;
    assign bus.fault   = r_fault;
    assign bus.rd_data = r_rd_data;
    assign bus.busy    = bus.mreq && !r_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder, three latency
//               builds (1, 0, 3) against a byte-addressed transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int         c_depth = 64;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [2:0]  t_mreq;
    logic [2:0]  t_write;
    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];
    logic [1:0]  t_size  [3];

    logic [2:0]  d_ready;
    logic [2:0]  d_fault;
    logic [2:0]  d_busy;
    logic [31:0] d_rd [3];

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();

    assign bus0.mreq = t_mreq[0];  assign bus0.write = t_write[0];
    assign bus0.addr = t_addr[0];  assign bus0.access_size = t_size[0];
    assign bus0.wr_data = t_wdata[0];
    assign bus1.mreq = t_mreq[1];  assign bus1.write = t_write[1];
    assign bus1.addr = t_addr[1];  assign bus1.access_size = t_size[1];
    assign bus1.wr_data = t_wdata[1];
    assign bus2.mreq = t_mreq[2];  assign bus2.write = t_write[2];
    assign bus2.addr = t_addr[2];  assign bus2.access_size = t_size[2];
    assign bus2.wr_data = t_wdata[2];

    assign d_ready = {bus2.ready, bus1.ready, bus0.ready};
    assign d_fault = {bus2.fault, bus1.fault, bus0.fault};
    assign d_busy  = {bus2.busy,  bus1.busy,  bus0.busy};
    assign d_rd[0] = bus0.rd_data;
    assign d_rd[1] = bus1.rd_data;
    assign d_rd[2] = bus2.rd_data;

    data_mem_responder #(.DEPTH_WORDS(c_depth), .LATENCY(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    data_mem_responder #(.DEPTH_WORDS(c_depth), .LATENCY(0)) u_dut_lat0 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    data_mem_responder #(.DEPTH_WORDS(c_depth), .LATENCY(3)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%08h expected=%08h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit mfault(input logic [31:0] a, input logic [1:0] s);
        if (s == SZ_X)                   return 1'b1;
        if (s == SZ_H && (a % 2) != 0)   return 1'b1;
        if (s == SZ_W && (a % 4) != 0)   return 1'b1;
        if ((a / 4) >= c_depth)          return 1'b1;
        return 1'b0;
    endfunction

    // Transaction model: byte-addressed little-endian memory per DUT, with
    // the response due LATENCY edges after the accepting edge.
    int          cyc;
    bit          m_pend [3];
    int          m_due  [3];
    int          m_free [3];
    logic        m_w    [3];
    logic [31:0] m_a    [3];
    logic [31:0] m_d    [3];
    logic [1:0]  m_s    [3];
    logic        e_ready [3];
    logic        e_fault [3];
    logic [31:0] e_rd    [3];
    logic [7:0]  mm [3][c_depth*4];
    bit          cmp_en;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int n;
            e_ready[k] = 1'b0;
            e_fault[k] = 1'b0;
            e_rd[k]    = 32'd0;
            if (!rst_n) begin
                m_pend[k] = 1'b0;
                m_free[k] = 0;
            end else begin
                if (!m_pend[k] && cyc >= m_free[k] && t_mreq[k]) begin
                    m_pend[k] = 1'b1;
                    m_w[k] = t_write[k];
                    m_a[k] = t_addr[k];
                    m_s[k] = t_size[k];
                    m_d[k] = t_wdata[k];
                    m_due[k]  = cyc + lat_of(k);
                    m_free[k] = cyc + lat_of(k) + 2;
                end
                if (m_pend[k] && cyc == m_due[k]) begin
                    m_pend[k]  = 1'b0;
                    e_ready[k] = 1'b1;
                    if (mfault(m_a[k], m_s[k])) begin
                        e_fault[k] = 1'b1;
                    end else begin
                        n = 1 << m_s[k];
                        for (int i = 0; i < n; i++) begin
                            if (m_w[k])
                                mm[k][int'(m_a[k]) + i] = m_d[k][8*i +: 8];
                            else
                                e_rd[k] = e_rd[k] | (32'(mm[k][int'(m_a[k]) + i]) << (8*i));
                        end
                    end
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                logic xr, xf;
                logic [31:0] xd;
                xr = rst_n ? e_ready[k] : 1'b0;
                xf = rst_n ? e_fault[k] : 1'b0;
                xd = rst_n ? e_rd[k]    : 32'd0;
                chk($sformatf("ready[%0d]@%0d", k, cyc), 32'(d_ready[k]), 32'(xr));
                chk($sformatf("fault[%0d]@%0d", k, cyc), 32'(d_fault[k]), 32'(xf));
                chk($sformatf("rd_data[%0d]@%0d", k, cyc), d_rd[k], xd);
                chk($sformatf("busy[%0d]@%0d", k, cyc), 32'(d_busy[k]), 32'(t_mreq[k] && !xr));
            end
        end
    end

    // Entered and left at one time unit after a falling edge.
    task automatic xact(input int k, input bit w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d,
                        input bit hold, input bit drop,
                        output logic [31:0] rd, output logic flt, output int lat);
        bit got;
        got = 1'b0;
        rd = 32'd0; flt = 1'b0; lat = 0;
        t_mreq[k] = 1'b1; t_write[k] = w; t_addr[k] = a; t_size[k] = s; t_wdata[k] = d;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); #1;
            if (d_ready[k]) begin
                got = 1'b1; lat = i; rd = d_rd[k]; flt = d_fault[k];
                break;
            end
            if (drop) t_mreq[k] = 1'b0;
        end
        if (!got) chk($sformatf("ready timeout dut%0d addr %08h", k, a), 32'd0, 32'd1);
        if (!hold) begin
            t_mreq[k] = 1'b0;
            @(negedge clk); #1;
        end
    endtask

    logic [31:0] rd;
    logic        flt;
    int          lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; cmp_en = 1'b0;
        t_mreq = 3'b000; t_write = 3'b000;
        for (int k = 0; k < 3; k++) begin
            t_addr[k] = 32'd0; t_wdata[k] = 32'd0; t_size[k] = SZ_W;
            m_pend[k] = 1'b0; m_due[k] = 0; m_free[k] = 0;
            e_ready[k] = 1'b0; e_fault[k] = 1'b0; e_rd[k] = 32'd0;
        end
        rst_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        chk("reset ready", 32'(d_ready), 32'd0);
        chk("reset fault", 32'(d_fault), 32'd0);
        chk("reset rd_data", d_rd[0], 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // LATENCY=1: word store/load round trip
        xact(0, 1, 32'h10, SZ_W, 32'hDEADBEEF, 0, 0, rd, flt, lat);
        chk("t1 store latency", lat, 2);
        chk("t1 store fault", 32'(flt), 0);
        xact(0, 0, 32'h10, SZ_W, 32'h0, 0, 0, rd, flt, lat);
        chk("t1 load latency", lat, 2);
        chk("t1 load data", rd, 32'hDEADBEEF);

        // byte merge and narrow loads
        xact(0, 1, 32'h13, SZ_B, 32'hFFFFFF5A, 0, 0, rd, flt, lat);
        xact(0, 0, 32'h10, SZ_W, 32'h0, 0, 0, rd, flt, lat);
        chk("t2 word after byte", rd, 32'h5AADBEEF);
        xact(0, 0, 32'h13, SZ_B, 32'h0, 0, 0, rd, flt, lat);
        chk("t2 byte load", rd, 32'h0000005A);
        xact(0, 0, 32'h12, SZ_H, 32'h0, 0, 0, rd, flt, lat);
        chk("t2 half load", rd, 32'h00005AAD);

        // faults
        xact(0, 0, 32'h11, SZ_H, 32'h0, 0, 0, rd, flt, lat);
        chk("t3 misaligned half fault", 32'(flt), 1);
        chk("t3 misaligned half data", rd, 32'h0);
        xact(0, 1, 32'h12, SZ_W, 32'h01020304, 0, 0, rd, flt, lat);
        chk("t3 misaligned word fault", 32'(flt), 1);
        xact(0, 1, 32'h0, SZ_X, 32'hFFFFFFFF, 0, 0, rd, flt, lat);
        chk("t3 illegal size fault", 32'(flt), 1);
        xact(0, 0, 32'h10, SZ_W, 32'h0, 0, 0, rd, flt, lat);
        chk("t3 word unchanged", rd, 32'h5AADBEEF);
        xact(0, 0, c_depth * 4, SZ_W, 32'h0, 0, 0, rd, flt, lat);
        chk("t4 out of range fault", 32'(flt), 1);

        // back-to-back loads with mreq held
        xact(0, 0, 32'h10, SZ_W, 32'h0, 1, 0, rd, flt, lat);
        chk("t6 first latency", lat, 2);
        xact(0, 0, 32'h13, SZ_B, 32'h0, 1, 0, rd, flt, lat);
        chk("t6 second latency", lat, 3);
        chk("t6 second data", rd, 32'h0000005A);
        xact(0, 0, 32'h12, SZ_H, 32'h0, 0, 0, rd, flt, lat);
        chk("t6 third latency", lat, 3);
        chk("t6 third data", rd, 32'h00005AAD);

        // reset during WAIT aborts the store
        xact(0, 1, 32'h20, SZ_W, 32'h55667788, 0, 0, rd, flt, lat);
        t_mreq[0] = 1'b1; t_write[0] = 1'b1; t_addr[0] = 32'h20;
        t_size[0] = SZ_W; t_wdata[0] = 32'h11223344;
        @(posedge clk); #2;
        rst_n = 1'b0; t_mreq[0] = 1'b0;
        #1;
        chk("t5 ready in reset", 32'(d_ready[0]), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        xact(0, 0, 32'h20, SZ_W, 32'h0, 0, 0, rd, flt, lat);
        chk("t5 old value kept", rd, 32'h55667788);

        // reset during RESP clears outputs at once
        xact(0, 0, 32'h10, SZ_W, 32'h0, 1, 0, rd, flt, lat);
        chk("t5 resp data before reset", rd, 32'h5AADBEEF);
        rst_n = 1'b0; t_mreq[0] = 1'b0;
        #1;
        chk("t5 ready cleared", 32'(d_ready[0]), 0);
        chk("t5 rd_data cleared", d_rd[0], 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // LATENCY=0 build
        xact(1, 1, 32'h40, SZ_W, 32'hCAFEF00D, 0, 0, rd, flt, lat);
        chk("lat0 store latency", lat, 1);
        xact(1, 0, 32'h42, SZ_H, 32'h0, 0, 0, rd, flt, lat);
        chk("lat0 half load", rd, 32'h0000CAFE);
        chk("lat0 load latency", lat, 1);
        xact(1, 0, 32'h41, SZ_B, 32'h0, 0, 0, rd, flt, lat);
        chk("lat0 byte load", rd, 32'h000000F0);
        xact(1, 0, c_depth * 4, SZ_W, 32'h0, 0, 0, rd, flt, lat);
        chk("lat0 out of range fault", 32'(flt), 1);

        // LATENCY=3 build, including mreq dropped early
        xact(2, 1, 32'h3C, SZ_W, 32'h00000000, 0, 0, rd, flt, lat);
        xact(2, 1, 32'h3E, SZ_H, 32'h1234BEEF, 0, 0, rd, flt, lat);
        xact(2, 0, 32'h3C, SZ_W, 32'h0, 0, 0, rd, flt, lat);
        chk("lat3 word after half", rd, 32'hBEEF0000);
        chk("lat3 latency", lat, 4);
        xact(2, 0, 32'h3F, SZ_B, 32'h0, 0, 1, rd, flt, lat);
        chk("lat3 early drop data", rd, 32'h000000BE);
        chk("lat3 early drop latency", lat, 4);

        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
